// File: rtl/hub75_input_capture.sv
// HUB75 panel emulator: rebuilds each latched column and measures its OE-low on-time, then emits one AXI-Stream beat.
// Optional HUB75_CAPTURE_STATS_EN adds col_count / short_count statistics outputs.
module hub75_input_capture #(
    parameter int NUM_PIXELS   = 64,
    parameter int ON_W         = 16,
    parameter int WAIT_TIMEOUT = 1024
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [2:0]                  rgb0,
    input  logic [2:0]                  rgb1,
    input  logic                        led_clk,
    input  logic                        led_latch,
    input  logic                        led_output_enable,
    output logic [2:0][NUM_PIXELS-1:0]  column_out0,
    output logic [2:0][NUM_PIXELS-1:0]  column_out1,
    output logic [ON_W-1:0]             on_time,
    output logic                        short_shift,
    output logic                        tvalid,
    input  logic                        tready,
    output logic                        tlast,
    output logic                        latch_overrun,
    output logic [1:0]                  fsm_state
`ifdef HUB75_CAPTURE_STATS_EN
    ,
    output logic [31:0]                 col_count,
    output logic [15:0]                 short_count
`endif
);

    localparam int PIX_W  = $clog2(NUM_PIXELS + 1);
    localparam int IDX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_SHIFT   = 2'd0,
        S_WAIT_ON = 2'd1,
        S_ON      = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0] rgb0_q, rgb1_q;
    logic       clk_q, clk_d, latch_q, latch_d, oe_q, oe_d;

    logic [2:0][NUM_PIXELS-1:0] sb0, sb1, sb0_next, sb1_next;
    logic [PIX_W-1:0]           pix_idx, pix_cnt_next;
    logic [IDX_W-1:0]           pix_sel;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [ON_W-1:0]            on_cnt;

    logic clk_rise, latch_rise, shift_ok;
    logic load_col, wait_expired;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rgb0_q  <= '0;
            rgb1_q  <= '0;
            clk_q   <= 1'b0;
            clk_d   <= 1'b0;
            latch_q <= 1'b0;
            latch_d <= 1'b0;
            oe_q    <= 1'b1;
            oe_d    <= 1'b1;
        end else begin
            rgb0_q  <= rgb0;
            rgb1_q  <= rgb1;
            clk_q   <= led_clk;
            clk_d   <= clk_q;
            latch_q <= led_latch;
            latch_d <= latch_q;
            oe_q    <= led_output_enable;
            oe_d    <= oe_q;
        end
    end

    assign clk_rise     = clk_q & ~clk_d;
    assign latch_rise   = latch_q & ~latch_d;
    assign shift_ok     = clk_rise && (pix_idx < PIX_W'(NUM_PIXELS));
    assign pix_sel      = pix_idx[IDX_W-1:0];
    assign pix_cnt_next = pix_idx + PIX_W'(shift_ok);
    assign wait_expired = (wait_cnt == WAIT_W'(WAIT_TIMEOUT - 1));
    assign fsm_state    = state;

    // Shift-buffer view with this cycle's pixel applied, so a latch coinciding with a clock captures it.
    always_comb begin
        sb0_next = sb0;
        sb1_next = sb1;
        if (shift_ok) begin
            for (int c = 0; c < 3; c++) begin
                sb0_next[c][pix_sel] = rgb0_q[c];
                sb1_next[c][pix_sel] = rgb1_q[c];
            end
        end
    end

    always_comb begin
        state_next = state;
        load_col   = 1'b0;
        case (state)
            S_SHIFT: begin
                if (latch_rise) begin
                    load_col   = 1'b1;
                    state_next = S_WAIT_ON;
                end
            end
            S_WAIT_ON: begin
                if (!oe_q)             state_next = S_ON;
                else if (wait_expired) state_next = S_EMIT;
            end
            S_ON: begin
                if (oe_q) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (tready) state_next = S_SHIFT;
            end
            default: state_next = S_SHIFT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_SHIFT;
        end else begin
            state <= state_next;
        end
    end

    // The shift buffer is deliberately not reset: it only ever holds pin data.
    always_ff @(posedge clk_in) begin
        sb0 <= sb0_next;
        sb1 <= sb1_next;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pix_idx       <= '0;
            wait_cnt      <= '0;
            on_cnt        <= '0;
            column_out0   <= '0;
            column_out1   <= '0;
            on_time       <= '0;
            short_shift   <= 1'b0;
            tvalid        <= 1'b0;
            tlast         <= 1'b0;
            latch_overrun <= 1'b0;
        end else begin
            pix_idx <= latch_rise ? '0 : pix_cnt_next;

            if (load_col) begin
                column_out0 <= sb0_next;
                column_out1 <= sb1_next;
                short_shift <= (pix_cnt_next != PIX_W'(NUM_PIXELS));
                wait_cnt    <= '0;
            end else if (state == S_WAIT_ON && oe_q) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == S_WAIT_ON && !oe_q) begin
                on_cnt <= ON_W'(1);
            end else if (state == S_ON && !oe_q && on_cnt != {ON_W{1'b1}}) begin
                on_cnt <= on_cnt + 1'b1;
            end

            if (state == S_WAIT_ON && oe_q && wait_expired) begin
                on_time <= '0;
            end else if (state == S_ON && oe_q) begin
                on_time <= on_cnt;
            end

            tvalid <= (state_next == S_EMIT);
            tlast  <= (state_next == S_EMIT);

            if (latch_rise && state != S_SHIFT) begin
                latch_overrun <= 1'b1;
            end
        end
    end

`ifdef HUB75_CAPTURE_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            col_count   <= '0;
            short_count <= '0;
        end else if (tvalid && tready) begin
            col_count <= col_count + 1'b1;
            if (short_shift && short_count != 16'hFFFF) begin
                short_count <= short_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hub75_input_capture.sv
// Bench for hub75_input_capture: drives HUB75 pin activity, models the shift buffer and scores AXI-Stream beats.
module tb_hub75_input_capture;

    localparam int NP   = 64;
    localparam int ON_W = 16;
    localparam int CW   = 3 * NP;
    localparam int W    = 2 * CW + ON_W + 1;

    logic                clk_in = 1'b0;
    logic                rst_in = 1'b1;
    logic [2:0]          rgb0 = '0, rgb1 = '0;
    logic                led_clk = 1'b0, led_latch = 1'b0, led_output_enable = 1'b1;
    logic [2:0][NP-1:0]  column_out0, column_out1;
    logic [ON_W-1:0]     on_time;
    logic                short_shift, tvalid, tlast, latch_overrun;
    logic                tready = 1'b1;
    logic [1:0]          fsm_state;
`ifdef HUB75_CAPTURE_STATS_EN
    logic [31:0]         col_count;
    logic [15:0]         short_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0]        exp_q[$];
    logic [2:0][NP-1:0]  m_sb0 = '0, m_sb1 = '0;
    int                  m_idx = 0;

    hub75_input_capture #(.NUM_PIXELS(NP), .ON_W(ON_W), .WAIT_TIMEOUT(1024)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rgb0(rgb0), .rgb1(rgb1),
        .led_clk(led_clk), .led_latch(led_latch), .led_output_enable(led_output_enable),
        .column_out0(column_out0), .column_out1(column_out1), .on_time(on_time),
        .short_shift(short_shift), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .latch_overrun(latch_overrun), .fsm_state(fsm_state)
`ifdef HUB75_CAPTURE_STATS_EN
        , .col_count(col_count), .short_count(short_count)
`endif
    );

    // clock / reset
    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    // driver tasks
    task automatic model_shift(input logic [2:0] r0, input logic [2:0] r1);
        if (m_idx < NP) begin
            for (int c = 0; c < 3; c++) begin
                m_sb0[c][m_idx] = r0[c];
                m_sb1[c][m_idx] = r1[c];
            end
            m_idx++;
        end
    endtask

    task automatic shift_pixel(input logic [2:0] r0, input logic [2:0] r1);
        model_shift(r0, r1);
        rgb0 = r0;
        rgb1 = r1;
        led_clk = 1'b1;
        tick(2);
        led_clk = 1'b0;
        tick(2);
    endtask

    task automatic push_expected(input int oe_n);
        exp_q.push_back({m_sb0, m_sb1, ON_W'(oe_n), (m_idx != NP)});
        m_idx = 0;
    endtask

    task automatic oe_pulse(input int oe_n);
        if (oe_n > 0) begin
            led_output_enable = 1'b0;
            tick(oe_n);
            led_output_enable = 1'b1;
        end
        tick(2);
    endtask

    task automatic latch_col(input int oe_n);
        push_expected(oe_n);
        led_latch = 1'b1;
        tick(2);
        led_latch = 1'b0;
        oe_pulse(oe_n);
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain_timeout: %0d beats still pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // scoreboard
    always @(negedge clk_in) begin
        logic [W-1:0] e;
        if (!rst_in && tvalid && tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_beat: tvalid=1 with no expected beat queued");
            end else begin
                e = exp_q.pop_front();
                if (column_out0 !== e[W-1 -: CW]) begin
                    n_fails++;
                    $display("FAIL beat_col0: got %h required %h", column_out0, e[W-1 -: CW]);
                end
                n_checks++;
                if (column_out1 !== e[W-1-CW -: CW]) begin
                    n_fails++;
                    $display("FAIL beat_col1: got %h required %h", column_out1, e[W-1-CW -: CW]);
                end
                n_checks++;
                if (on_time !== e[ON_W:1]) begin
                    n_fails++;
                    $display("FAIL beat_on_time: got %0d required %0d", on_time, e[ON_W:1]);
                end
                n_checks++;
                if (short_shift !== e[0]) begin
                    n_fails++;
                    $display("FAIL beat_short_shift: got %b required %b", short_shift, e[0]);
                end
                n_checks++;
                if (tlast !== 1'b1) begin
                    n_fails++;
                    $display("FAIL beat_tlast: got %b required 1", tlast);
                end
            end
        end
    end

    task automatic test_reset();
        rst_in = 1'b1;
        tick(3);
        n_checks++;
        if ({column_out0, column_out1, on_time, short_shift, tvalid, tlast, latch_overrun, fsm_state} !== '0) begin
            n_fails++;
            $display("FAIL reset_values: got tvalid=%b tlast=%b ovr=%b short=%b on=%0d st=%0d, required all zero",
                     tvalid, tlast, latch_overrun, short_shift, on_time, fsm_state);
        end
        rst_in = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        for (int p = 0; p < NP; p++) shift_pixel(3'(p % 8), 3'(~p));
        latch_col(10);
        wait_drain(50);
        n_checks++;
        if (column_out0[0][5] !== 1'b1) begin
            n_fails++;
            $display("FAIL basic_pixel5: got %b required 1", column_out0[0][5]);
        end
    endtask

    task automatic test_short();
        for (int p = 0; p < 40; p++) shift_pixel(3'((p + 3) % 8), 3'($urandom_range(0, 7)));
        latch_col(7);
        wait_drain(50);
        for (int p = 0; p < 70; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_col(4);
        wait_drain(50);
    endtask

    task automatic test_timeout();
        for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_col(0);
        wait_drain(1200);
    endtask

    task automatic test_overrun();
        logic [W-1:0] front;
        tready = 1'b0;
        for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_col(5);
        front = exp_q[0];
        tick(200);
        for (int p = 0; p < 8; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        led_latch = 1'b1;
        tick(2);
        led_latch = 1'b0;
        m_idx = 0;
        tick(3);
        n_checks++;
        if (tvalid !== 1'b1 || latch_overrun !== 1'b1) begin
            n_fails++;
            $display("FAIL overrun_flags: got tvalid=%b overrun=%b required 1 1", tvalid, latch_overrun);
        end
        n_checks++;
        if (column_out0 !== front[W-1 -: CW] || on_time !== front[ON_W:1]) begin
            n_fails++;
            $display("FAIL overrun_hold: got on_time=%0d required %0d (column data may differ too)",
                     on_time, front[ON_W:1]);
        end
        tready = 1'b1;
        wait_drain(20);
        for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_col(12);
        wait_drain(50);
    endtask

    task automatic test_coincident();
        logic [2:0] r0, r1;
        for (int p = 0; p < NP - 1; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        r0 = 3'b101;
        r1 = 3'b011;
        model_shift(r0, r1);
        push_expected(6);
        rgb0 = r0;
        rgb1 = r1;
        led_clk = 1'b1;
        led_latch = 1'b1;
        tick(2);
        led_clk = 1'b0;
        led_latch = 1'b0;
        oe_pulse(6);
        wait_drain(50);
    endtask

    task automatic test_on_sequence();
        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            latch_col(10 * (k % 3 + 1));
            wait_drain(80);
        end
    endtask

    task automatic test_reset_mid_on();
        for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        led_latch = 1'b1;
        tick(2);
        led_latch = 1'b0;
        led_output_enable = 1'b0;
        tick(6);
        n_checks++;
        if (fsm_state !== 2'd2) begin
            n_fails++;
            $display("FAIL mid_on_state: got %0d required 2", fsm_state);
        end
        rst_in = 1'b1;
        tick(1);
        n_checks++;
        if (tvalid !== 1'b0 || fsm_state !== 2'd0 || on_time !== '0) begin
            n_fails++;
            $display("FAIL mid_on_reset: got tvalid=%b state=%0d on_time=%0d required 0 0 0",
                     tvalid, fsm_state, on_time);
        end
        rst_in = 1'b0;
        led_output_enable = 1'b1;
        m_idx = 0;
        tick(20);
        for (int p = 0; p < NP; p++) shift_pixel(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_col(3);
        wait_drain(50);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_timeout();
        test_overrun();
        test_coincident();
        test_on_sequence();
        test_reset_mid_on();
        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
